// File: rtl/enlynx_readout.sv
// Counter-snapshot readout: latches an event-encoder counter vector and
// streams it out as a framed word sequence (header, counters, overflow flags).
module enlynx_readout #(
  parameter int N_METRICS     = 13,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [N_METRICS-1:0][COUNTER_WIDTH-1:0]  counters_i,
  input  logic [N_METRICS-1:0]                     overflow_i,
  input  logic                                     capture_i,
  input  logic                                     eop_i,
  output logic [COUNTER_WIDTH-1:0]                 data_o,
  output logic                                     valid_o,
  input  logic                                     ready_i,
  output logic                                     last_o,
  output logic                                     busy_o,
  output logic [7:0]                               dropped_o
);

  localparam int IDX_W = (N_METRICS > 1) ? $clog2(N_METRICS) : 1;

  typedef enum logic [1:0] {IDLE, HEADER, DATA, FLAGS} state_t;

  state_t                   state;
  logic [COUNTER_WIDTH-1:0] snap [N_METRICS];
  logic [N_METRICS-1:0]     snap_ovf;
  logic [7:0]               seq;
  logic [IDX_W-1:0]         index;

  logic                     pulse;
  logic                     handshake;
  logic [IDX_W-1:0]         index_next;
  logic [COUNTER_WIDTH-1:0] header_word;

  assign pulse       = capture_i | eop_i;
  assign handshake   = valid_o & ready_i;
  assign index_next  = index + 1'b1;
  // Type bit follows eop_i, so a coincident capture/eop yields an eop frame.
  assign header_word = COUNTER_WIDTH'({8'hA5, seq, 8'(N_METRICS), 7'd0, eop_i});

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      data_o    <= '0;
      valid_o   <= 1'b0;
      last_o    <= 1'b0;
      busy_o    <= 1'b0;
      seq       <= '0;
      dropped_o <= '0;
      index     <= '0;
      snap_ovf  <= '0;
      // NOTE: the snapshot array is cleared on reset because a known-zero
      // snapshot is part of the reset state; plain storage would skip this.
      for (int i = 0; i < N_METRICS; i++) snap[i] <= '0;
    end else begin
      if (state != IDLE && pulse && dropped_o != 8'hFF)
        dropped_o <= dropped_o + 8'd1;

      case (state)
        IDLE: begin
          if (pulse) begin
            for (int i = 0; i < N_METRICS; i++) snap[i] <= counters_i[i];
            snap_ovf <= overflow_i;
            data_o   <= header_word;
            valid_o  <= 1'b1;
            busy_o   <= 1'b1;
            seq      <= seq + 8'd1;
            state    <= HEADER;
          end
        end
        HEADER: begin
          if (handshake) begin
            data_o <= snap[0];
            index  <= '0;
            state  <= DATA;
          end
        end
        DATA: begin
          if (handshake) begin
            if (index == IDX_W'(N_METRICS - 1)) begin
              data_o <= COUNTER_WIDTH'(snap_ovf);
              last_o <= 1'b1;
              state  <= FLAGS;
            end else begin
              index  <= index_next;
              data_o <= snap[index_next];
            end
          end
        end
        FLAGS: begin
          if (handshake) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            busy_o  <= 1'b0;
            index   <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enlynx_readout.sv
// Scoreboard bench for enlynx_readout: a frame-level reference model queues
// expected words; a negedge monitor compares every handshake and status output.
module tb_enlynx_readout;

  localparam int N = 13;
  localparam int W = 32;

  logic                 clk;
  logic                 rst_n;
  logic [N-1:0][W-1:0]  counters_i;
  logic [N-1:0]         overflow_i;
  logic                 capture_i;
  logic                 eop_i;
  logic [W-1:0]         data_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 last_o;
  logic                 busy_o;
  logic [7:0]           dropped_o;

  enlynx_readout #(.N_METRICS(N), .COUNTER_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .counters_i(counters_i), .overflow_i(overflow_i),
    .capture_i(capture_i), .eop_i(eop_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .last_o(last_o), .busy_o(busy_o), .dropped_o(dropped_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  exp_t       exp_q [$];
  int         words_left = 0;
  logic [7:0] m_seq = 8'd0;
  int         m_drop = 0;
  bit         after_rst = 1'b0;
  int         compared = 0;
  int         mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is N+2 words; while words remain every ready cycle
  // consumes one and every pulse is a drop.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      words_left = 0;
      m_seq      = 8'd0;
      m_drop     = 0;
      after_rst  = 1'b1;
    end else begin
      after_rst = 1'b0;
      if (words_left > 0) begin
        if ((capture_i || eop_i) && m_drop < 255) m_drop++;
        if (ready_i) words_left--;
      end else if (capture_i || eop_i) begin
        exp_t e;
        e.data = W'({8'hA5, m_seq, 8'(N), 7'd0, eop_i});
        e.last = 1'b0;
        exp_q.push_back(e);
        for (int i = 0; i < N; i++) begin
          e.data = counters_i[i];
          exp_q.push_back(e);
        end
        e.data = W'(overflow_i);
        e.last = 1'b1;
        exp_q.push_back(e);
        words_left = N + 2;
        m_seq      = m_seq + 8'd1;
      end
    end
  end

  bit           stalled_prev = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_last;

  always @(negedge clk) begin
    check("valid", valid_o, words_left > 0);
    check("busy", busy_o, words_left > 0);
    check("dropped", dropped_o, m_drop);
    if (!valid_o) check("last_idle", last_o, 1'b0);
    if (after_rst) check("reset_data", data_o, '0);
    if (stalled_prev && !after_rst) begin
      check("stall_valid", valid_o, 1'b1);
      check("stall_data", data_o, prev_data);
      check("stall_last", last_o, prev_last);
    end
    if (valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_word: got %h expected no word (t=%0t)", data_o, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("data", data_o, e.data);
        check("last", last_o, e.last);
      end
    end
    stalled_prev = valid_o && !ready_i;
    prev_data    = data_o;
    prev_last    = last_o;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_capture();
    capture_i = 1'b1;
    cyc();
    capture_i = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    ready_i = 1'b1;
    while (words_left > 0 && n < max_cycles) begin
      cyc();
      n++;
    end
    if (words_left > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d words outstanding required 0", words_left);
    end
  endtask

  task automatic randomize_counters();
    for (int i = 0; i < N; i++) counters_i[i] = $urandom;
    overflow_i = N'($urandom);
  endtask

  initial begin
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst_n = 1'b0; capture_i = 1'b0; eop_i = 1'b0; ready_i = 1'b0;
    counters_i = '0; overflow_i = '0;

    // Pulse during reset is ignored and not counted.
    cyc(); pulse_capture(); cyc();
    rst_n = 1'b1;

    // Basic section frame with counters i+1.
    for (int i = 0; i < N; i++) counters_i[i] = W'(i + 1);
    ready_i = 1'b1;
    pulse_capture();
    drain(100);

    // Coincident eop/capture with overflow flags.
    overflow_i = 13'h1001;
    eop_i = 1'b1; capture_i = 1'b1;
    cyc();
    eop_i = 1'b0; capture_i = 1'b0;
    drain(100);

    // Ready toggling 1,0,0,1 during the frame.
    pulse_capture();
    for (int k = 0; k < 80 && words_left > 0; k++) begin
      ready_i = pat[k % 4];
      cyc();
    end
    drain(100);

    // Drops mid-frame; counters change under a stalled frame.
    ready_i = 1'b0;
    pulse_capture();
    for (int k = 0; k < 3; k++) begin
      cyc();
      pulse_capture();
      randomize_counters();
    end
    drain(100);
    pulse_capture();
    drain(100);

    // Saturation of the drop counter.
    ready_i = 1'b0;
    pulse_capture();
    for (int k = 0; k < 300; k++) begin
      pulse_capture();
      cyc();
    end
    drain(100);

    // Reset in the middle of the DATA phase, then a fresh frame.
    for (int i = 0; i < N; i++) counters_i[i] = W'(i + 1);
    ready_i = 1'b1;
    pulse_capture();
    repeat (6) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    pulse_capture();
    drain(100);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      randomize_counters();
      capture_i = ($urandom_range(15) == 0);
      eop_i     = ($urandom_range(31) == 0);
      ready_i   = ($urandom_range(3) != 0);
      rst_n     = ($urandom_range(699) != 0);
      cyc();
    end
    capture_i = 1'b0; eop_i = 1'b0; rst_n = 1'b1;
    drain(200);

    // 257 back-to-back frames from a clean reset to exercise sequence wrap.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    ready_i = 1'b1;
    for (int f = 0; f < 257; f++) begin
      randomize_counters();
      pulse_capture();
      repeat (N + 2) cyc();
    end
    drain(100);
    cyc();

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
